// File: rtl/pulse_tx_if.sv
// Handshake and line bundle between a pulse-train controller and pulse_tx.
// Latency: none, this is wiring only.
// Backpressure: none. start is a request that pulse_tx accepts only while idle, and busy/done report progress.
// Ports:
//   start, count, gap : controller -> pulse_tx (train request and parameters)
//   req, inh          : pulse_tx -> downstream pulse detector
//   busy, done        : pulse_tx -> controller (progress and completion strobe)
interface pulse_tx_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] gap;
  logic             req;
  logic             inh;
  logic             busy;
  logic             done;

  // Controller side.
  modport master (
    output start,
    output count,
    output gap,
    input  req,
    input  inh,
    input  busy,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  start,
    input  count,
    input  gap,
    output req,
    output inh,
    output busy,
    output done
  );
endinterface

// File: rtl/pulse_tx.sv
// Emits a train of count one-cycle qualified request pulses (req=1, inh=0), separated by gap idle cycles.
// Latency: start accepted at edge k gives req/busy high in the cycle after edge k. All outputs are registered.
// Backpressure: start is honoured only in IDLE and ignored otherwise. busy stays high through the DONE strobe cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, forces IDLE outputs immediately
//   bus   : pulse_tx_if slave modport (start/count/gap in; req/inh/busy/done out)
module pulse_tx #(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  pulse_tx_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] rem_cnt_q, rem_cnt_d;
  logic [CNT_W-1:0] gap_q,     gap_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  logic req_q,  req_d;
  logic inh_q,  inh_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    rem_cnt_d = rem_cnt_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.count != CNT_ZERO) begin
            rem_cnt_d = bus.count;
            gap_d     = bus.gap;
            state_d   = ST_PULSE;
          end else begin
            // An empty train still gives the controller its done strobe.
            state_d = ST_DONE;
          end
        end
      end

      ST_PULSE: begin
        // rem_cnt is never 0 here, so the decrement cannot wrap.
        rem_cnt_d = rem_cnt_q - CNT_ONE;
        if (rem_cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else if (gap_q == CNT_ZERO) begin
          state_d = ST_PULSE;
        end else begin
          gap_cnt_d = gap_q;
          state_d   = ST_GAP;
        end
      end

      ST_GAP: begin
        // gap_cnt enters GAP as gap_q (>= 1) and leaves at 1, so GAP lasts
        // exactly gap_q cycles and the countdown never wraps.
        gap_cnt_d = gap_cnt_q - CNT_ONE;
        if (gap_cnt_q == CNT_ONE) begin
          state_d = ST_PULSE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered. This keeps the
  // pins glitch-free and aligned with the state they describe. req and inh are
  // always complementary, so the detector never sees req=1 with inh=1 and the
  // lines are never both low.
  always_comb begin
    req_d  = 1'b0;
    inh_d  = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;

    case (state_d)
      ST_IDLE: begin
        req_d  = 1'b0;
        inh_d  = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
      ST_PULSE: begin
        req_d  = 1'b1;
        inh_d  = 1'b0;
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      ST_GAP: begin
        req_d  = 1'b0;
        inh_d  = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b0;
      end
      ST_DONE: begin
        req_d  = 1'b0;
        inh_d  = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        req_d  = 1'b0;
        inh_d  = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_cnt_q <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_cnt_q <= rem_cnt_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // The output flops reset to the IDLE pattern. A reset mid-pulse therefore
  // drops req and raises inh at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q  <= 1'b0;
      inh_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      inh_q  <= inh_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.req  = req_q;
  assign bus.inh  = inh_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/pulse_tx.md
# pulse_tx

Pulse transmitter that drives the two inputs of the downstream registered pulse detector (inhibit line and request line). The detector fires only when inhibit is low and request is high, so this block produces a programmed train of qualified request pulses with programmable spacing. It sits on the same clock as the detector and uses a start/busy/done handshake toward its controller.

## Interface

- CNT_W, 8, width of the pulse count and gap fields
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request to begin a pulse train; sampled only in IDLE
- count  input  CNT_W  number of request pulses in the train; sampled with start
- gap  input  CNT_W  idle cycles between consecutive pulses; sampled with start
- req  output  1  request line, drives the detector's request input
- inh  output  1  inhibit line, drives the detector's inhibit input
- busy  output  1  high while a train is in progress, including the DONE cycle
- done  output  1  single-cycle completion strobe

## Operation

- All outputs are registered and decoded from state. There is no combinational path from inputs to outputs.
- Internal registers:
  - rem_cnt (CNT_W): pulses remaining.
  - gap_q (CNT_W): latched gap value.
  - gap_cnt (CNT_W): gap countdown.
- States:
  - IDLE: req=0, inh=1, busy=0, done=0.
  - PULSE: req=1, inh=0, busy=1, done=0. Lasts exactly one cycle per pulse.
  - GAP: req=0, inh=1, busy=1, done=0.
  - DONE: req=0, inh=1, busy=1, done=1. Lasts one cycle.
- Transitions:
  - IDLE, start=1, count!=0: latch rem_cnt=count and gap_q=gap, then go to PULSE.
  - IDLE, start=1, count==0: go to DONE. No pulse is emitted; the controller still receives done.
  - PULSE: decrement rem_cnt.
    - If the decremented value is 0, go to DONE.
    - Otherwise, if gap_q==0, stay in PULSE (back-to-back pulses; req stays 1 and inh stays 0).
    - Otherwise, load gap_cnt=gap_q and go to GAP.
  - GAP: decrement gap_cnt. When it reaches 0, go to PULSE. GAP therefore lasts exactly gap_q cycles.
  - DONE: go to IDLE unconditionally.
- start outside IDLE is ignored, including start in the DONE cycle. count and gap changes after acceptance have no effect on the current train.
- Counters never wrap. The maximum count of 2^CNT_W-1 and the maximum gap of 2^CNT_W-1 are both legal.
- req=1 together with inh=1 never occurs. req=0 together with inh=0 never occurs.

## Timing

- Reset (asynchronous, immediate, also mid-train): state=IDLE, req=0, inh=1, busy=0, done=0, and all counters are 0. No partial pulse is produced after reset deasserts. The first edge after release behaves as IDLE.
- Start latency: start sampled high at edge k puts req=1 and busy=1 in the cycle following edge k.
- Pulse period: gap_q+1 cycles. Each pulse is exactly 1 cycle wide, except back-to-back pulses when gap_q=0, where req is held high for count cycles.
- Train length:
  - busy stays high for count + (count-1)*gap + 1 cycles.
  - done is asserted in the last of these cycles.
  - For count=0, busy and done are high for 1 cycle.
- Earliest restart: a new start can be accepted at the edge where state is IDLE, which is the cycle after DONE. Minimum start-to-start spacing is train length + 1.

## Test plan

- Reset mid-train: count=5, gap=2; assert reset during the 2nd GAP cycle. Required: req=0, inh=1, busy=0, done=0 immediately and without waiting for a clock edge. After release, no pulses occur until a new start.
- Basic train: count=3, gap=2, start high for 1 cycle. Required: req high in cycles 1, 4 and 7 after the start edge; inh is the exact complement of req; done high in cycle 8; busy high for cycles 1-8. The detector registers 3 qualified pulses.
- Back-to-back: count=4, gap=0. Required: req held high for 4 consecutive cycles, then done for 1 cycle; busy high for 5 cycles.
- Zero count: count=0, gap=7. Required: req never rises; busy=1 and done=1 for exactly 1 cycle, then IDLE.
- Start while busy: count=2, gap=3; pulse start again, with count=9, during GAP and during DONE. Required: both are ignored, exactly 2 pulses are emitted, and the original timing is unchanged. A start in the cycle after DONE is accepted.
- Max values: with CNT_W=4, count=15 and gap=15. Required: 15 pulses spaced 16 cycles apart, busy for 15+14*15+1=226 cycles, and no counter wrap or extra pulse.
